// File: rtl/simon_dec_seq.sv
// Iterative SIMON 64/128 decrypt sequencer: one inverse round per clock, keys read k43..k0.
// Define SIMON_DEC_ENC_EN to add an encrypt mode selected by enc_dec at acceptance.
module simon_dec_seq #(
  parameter int unsigned ROUNDS  = 44,
  parameter int unsigned KADDR_W = 6
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_block,
  input  logic               enc_dec,
  output logic [KADDR_W-1:0] rk_addr,
  input  logic [31:0]        rk_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [63:0]        out_block,
  output logic               busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [KADDR_W-1:0] LastIdx = KADDR_W'(ROUNDS - 1);

  state_e             state_q;
  logic [31:0]        x_q, y_q;
  logic [31:0]        x_d, y_d;
  logic [KADDR_W-1:0] cnt_q, cnt_d;
  logic               last_round;

  function automatic logic [31:0] f_fn(input logic [31:0] v);
    return ({v[30:0], v[31]} & {v[23:0], v[31:24]}) ^ {v[29:0], v[31:30]};
  endfunction

`ifdef SIMON_DEC_ENC_EN
  logic enc_q;

  always_comb begin
    x_d        = y_q;
    y_d        = x_q ^ f_fn(y_q) ^ rk_data;
    cnt_d      = cnt_q - 1'b1;
    last_round = (cnt_q == '0);
    if (enc_q) begin
      x_d        = y_q ^ f_fn(x_q) ^ rk_data;
      y_d        = x_q;
      cnt_d      = cnt_q + 1'b1;
      last_round = (cnt_q == LastIdx);
    end
    // cnt returns to 0 after the final round so rk_addr reads 0 in DONE/IDLE
    if (last_round) cnt_d = '0;
  end
`else
  logic unused_enc_dec;
  assign unused_enc_dec = enc_dec;

  always_comb begin
    x_d        = y_q;
    y_d        = x_q ^ f_fn(y_q) ^ rk_data;
    last_round = (cnt_q == '0);
    cnt_d      = last_round ? '0 : cnt_q - 1'b1;
  end
`endif

  assign rk_addr   = cnt_q;
  assign out_block = {x_q, y_q};

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SIMON_DEC_ENC_EN
      enc_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q      <= in_block[63:32];
            y_q      <= in_block[31:0];
            state_q  <= StRun;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SIMON_DEC_ENC_EN
            enc_q    <= enc_dec;
            cnt_q    <= enc_dec ? '0 : LastIdx;
`else
            cnt_q    <= LastIdx;
`endif
          end
        end
        StRun: begin
          x_q   <= x_d;
          y_q   <= y_d;
          cnt_q <= cnt_d;
          if (last_round) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          cnt_q     <= '0;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simon_dec_seq.sv
// Self-checking bench for simon_dec_seq: known-answer vectors, handshake corners, random blocks.
module tb_simon_dec_seq;

  localparam int KADDR_W = 6;
  localparam int NR      = 44;
`ifdef SIMON_DEC_ENC_EN
  localparam bit EncEn = 1'b1;
`else
  localparam bit EncEn = 1'b0;
`endif

  localparam logic [127:0] StdKey = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  StdPt  = 64'h656b696c_20646e75;
  localparam logic [63:0]  StdCt  = 64'h44c8fc20_b9dfa07a;

  logic               ck = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               enc_dec = 1'b0;
  logic               out_ready = 1'b0;
  logic [63:0]        in_block = '0;
  logic               in_ready, out_valid, busy;
  logic [KADDR_W-1:0] rk_addr;
  logic [31:0]        rk_data;
  logic [63:0]        out_block;
  logic [31:0]        ks [64];

  int total = 0;
  int bad   = 0;

  simon_dec_seq #(.ROUNDS(NR), .KADDR_W(KADDR_W)) dut (
    .ck(ck), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
    .enc_dec(enc_dec), .rk_addr(rk_addr), .rk_data(rk_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_block(out_block), .busy(busy)
  );

  always #5 ck = ~ck;
  assign rk_data = ks[rk_addr];

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] rotr(input logic [31:0] v, input int n);
    return (v >> n) | (v << (32 - n));
  endfunction

  function automatic logic [31:0] ff(input logic [31:0] v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

  // SIMON 64/128 key schedule (m=4, constant sequence z3)
  task automatic expand(input logic [127:0] key);
    logic [61:0] z;
    logic [31:0] t;
    z = 62'b11011011101011000110010111100000010010001010011100110100001111;
    for (int i = 0; i < 64; i++) ks[i] = '0;
    for (int i = 0; i < 4; i++) ks[i] = key[32*i +: 32];
    for (int i = 4; i < NR; i++) begin
      t = rotr(ks[i-1], 3) ^ ks[i-3];
      t = t ^ rotr(t, 1);
      ks[i] = ~ks[i-4] ^ t ^ {31'b0, z[61-(i-4)]} ^ 32'd3;
    end
  endtask

  function automatic logic [63:0] enc_ref(input logic [63:0] b);
    logic [31:0] x, y, t;
    x = b[63:32];
    y = b[31:0];
    for (int i = 0; i < NR; i++) begin
      t = x;
      x = y ^ ff(x) ^ ks[i];
      y = t;
    end
    return {x, y};
  endfunction

  function automatic logic [63:0] dec_ref(input logic [63:0] b);
    logic [31:0] x, y, t;
    x = b[63:32];
    y = b[31:0];
    for (int i = NR - 1; i >= 0; i--) begin
      t = y;
      y = x ^ ff(y) ^ ks[i];
      x = t;
    end
    return {x, y};
  endfunction

  function automatic logic [63:0] ref_op(input logic [63:0] b, input bit enc);
    return (enc && EncEn) ? enc_ref(b) : dec_ref(b);
  endfunction

  // Offer a block, follow it to the result, stall the consumer, then hand it off.
  task automatic run_block(input logic [63:0] blk, input bit enc, input int stall, input bit jit,
                           output logic [63:0] res, output int lat, output int seqerr);
    int n, ea;
    in_block = blk;
    enc_dec  = enc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    tick();
    in_valid = 1'b0;
    enc_dec  = ~enc;
    lat = 0;
    seqerr = 0;
    while (!out_valid && lat < 200) begin
      ea = (enc && EncEn) ? lat : NR - 1 - lat;
      if (int'(rk_addr) != ea) seqerr++;
      if (jit) begin
        in_valid  = 1'($urandom);
        in_block  = {$urandom, $urandom};
        out_ready = 1'($urandom);
      end
      tick();
      lat++;
    end
    out_ready = 1'b0;
    repeat (stall) tick();
    in_valid  = 1'b0;
    res       = out_block;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [63:0] blk;
    bit          enc;
    logic [63:0] exp;
  } vec_t;

  initial begin
    vec_t        vt [6];
    logic [63:0] res, res2, hold, blk, b0, b1;
    int          lat, seqerr, errs, n;
    bit          enc;

    expand(StdKey);

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rk_addr", 64'(rk_addr), 64'd0);
    chk("rst_out_block", out_block, 64'd0);

    // Known-answer decrypt with exact latency and key order
    in_block = StdCt;
    enc_dec  = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("kat_busy", 64'(busy), 64'd1);
    chk("kat_in_ready", 64'(in_ready), 64'd0);
    errs = 0;
    for (int r = NR - 1; r >= 0; r--) begin
      if (int'(rk_addr) != r || out_valid) errs++;
      tick();
    end
    chk("kat_rk_seq", 64'(errs), 64'd0);
    chk("kat_out_valid", 64'(out_valid), 64'd1);
    chk("kat_result", out_block, StdPt);
    chk("kat_rk_done", 64'(rk_addr), 64'd0);

    // Backpressure: result held while the consumer stalls
    hold = out_block;
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_block = {$urandom, $urandom};
      tick();
      if (out_block !== hold || in_ready || !out_valid || !busy) errs++;
    end
    chk("bp_stable", 64'(errs), 64'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_in_ready", 64'(in_ready), 64'd1);
    chk("bp_out_valid", 64'(out_valid), 64'd0);
    chk("bp_busy", 64'(busy), 64'd0);

    // Back-to-back with in_valid held high
    b0 = 64'h0123_4567_89ab_cdef;
    b1 = 64'hfedc_ba98_7654_3210;
    in_block = b0;
    in_valid = 1'b1;
    tick();
    in_block = b1;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_first", out_block, dec_ref(b0));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n = 1;
    while (!busy && n < 10) begin
      tick();
      n++;
    end
    chk("b2b_accept_gap", 64'(n), 64'd2);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("b2b_second", out_block, dec_ref(b1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of a block
    in_block = StdCt;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("mid_rk_addr", 64'(rk_addr), 64'(NR - 1 - 20));
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rk_addr", 64'(rk_addr), 64'd0);
    tick();
    rst = 1'b0;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    run_block(StdCt, 1'b0, 0, 1'b0, res, lat, seqerr);
    chk("mid_rst_result", res, StdPt);

    // Vector table, including the encrypt-mode request
    vt[0] = '{StdCt, 1'b0, StdPt};
    vt[1] = '{StdPt, 1'b1, EncEn ? StdCt : dec_ref(StdPt)};
    vt[2] = '{enc_ref(64'd0), 1'b0, 64'd0};
    vt[3] = '{enc_ref('1), 1'b0, '1};
    vt[4] = '{64'h8000_0000_0000_0001, 1'b0, dec_ref(64'h8000_0000_0000_0001)};
    vt[5] = '{64'h1234_5678_9abc_def0, 1'b1, ref_op(64'h1234_5678_9abc_def0, 1'b1)};
    for (int i = 0; i < 6; i++) begin
      run_block(vt[i].blk, vt[i].enc, i, 1'b0, res, lat, seqerr);
      chk($sformatf("vec%0d_result", i), res, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NR));
      chk($sformatf("vec%0d_rk_seq", i), 64'(seqerr), 64'd0);
    end

    // Random blocks under a fresh random key with jittered handshakes
    expand({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 100; i++) begin
      blk = {$urandom, $urandom};
      enc = 1'($urandom);
      repeat ($urandom_range(0, 2)) tick();
      run_block(blk, enc, $urandom_range(0, 3), 1'b1, res, lat, seqerr);
      chk($sformatf("rand%0d_result", i), res, ref_op(blk, enc));
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'(NR));
      chk($sformatf("rand%0d_rk_seq", i), 64'(seqerr), 64'd0);
      if (i % 4 == 0) begin
        // Round trip: undo the first operation on the device itself
        if (EncEn && enc) run_block(res, 1'b0, 0, 1'b0, res2, lat, seqerr);
        else run_block(enc_ref(blk), 1'b0, 0, 1'b0, res2, lat, seqerr);
        chk($sformatf("rand%0d_roundtrip", i), res2, (EncEn && enc) ? blk : blk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
